set_assoc_cache: RTL and testbench
==================================

// Module: set_assoc_cache
// PURPOSE
//  Parametrised N-way set-associative, write-back, write-allocate data cache with true-LRU
//  replacement. Sits between the pipeline MEM stage and the line-wide data memory.
//  Unlike the direct-mapped generation, the memory port is external and uses a req/ready handshake.
//  The cache also keeps hit/miss statistics counters.
// PARAMETERS
//  LINE_SIZE   16   bytes per line; power of 2, >=4; WPL = LINE_SIZE/4 words per line
//  NUM_SETS    16   number of sets; power of 2, >=1
//  NUM_WAYS    2    ways per set; power of 2, 1..8 (1 = direct-mapped, LRU degenerate)
// PORTS
//  clk             in   1           clock, all state updates on posedge
//  reset           in   1           asynchronous, active-high
//  is_input_valid  in   1           CPU request valid
//  addr            in   32          byte address; [1:0] ignored
//  mem_read        in   1           load request (mutually exclusive with mem_write)
//  mem_write       in   1           store request
//  din             in   32          store data
//  is_ready        out  1           cache can accept a request this cycle
//  is_output_valid out  1           1-cycle pulse: request complete (load data valid / store done)
//  dout            out  32          load data, valid with is_output_valid
//  is_hit          out  1           valid with is_output_valid: 1 = request hit on first lookup
//  hit_count       out  32          hits since reset, wraps at 2^32
//  miss_count      out  32          misses since reset, wraps at 2^32
//  mem_req_valid   out  1           memory request valid; held until accepted
//  mem_req_ready   in   1           memory accepts request when valid&&ready on posedge
//  mem_req_write   out  1           1 = line write-back, 0 = line fill
//  mem_req_addr    out  32          line-aligned byte address (offset bits zero)
//  mem_wdata       out  8*LINE_SIZE write-back line, word 0 in bits [31:0]
//  mem_rvalid      in   1           fill data valid (1 cycle, any time after read accepted)
//  mem_rdata       in   8*LINE_SIZE fill line
// BEHAVIOUR
//  Address split: OFF=addr[2+:log2(WPL)], IDX=next log2(NUM_SETS) bits, TAG=remaining upper bits.
//  Per line: valid, dirty, tag, data; per set: log2(NUM_WAYS)-bit age per way (0 = MRU).
//  Reset: all valid/dirty=0, ages[w]=w, counters=0, state IDLE; outputs: is_ready=1,
//   is_output_valid=0, dout=0, is_hit=0, mem_req_valid=0, mem_req_write=0, addr/wdata=0.
//  Reset is honoured mid-miss: request is dropped, mem_req_valid falls immediately, dirty data is lost.
//  FSM states: IDLE, LOOKUP, WBACK, FILL_REQ, FILL_WAIT.
//   IDLE: is_ready=1; on is_input_valid&&(mem_read|mem_write), latch addr/din/op and go to LOOKUP.
//    A request with neither op set is ignored.
//   LOOKUP (is_ready=0): compare the tag against all ways of the set.
//    Hit: complete this cycle (is_output_valid=1 registered out next edge, i.e. 1 cycle after accept);
//     load returns the word at OFF; store writes din to OFF and sets dirty; way becomes MRU
//     (ages younger than the old age +1); increment hit_count unless the request is a post-fill replay;
//     -> IDLE.
//    Miss: increment miss_count once per request; victim = lowest-index invalid way, else way with
//     age NUM_WAYS-1; victim dirty -> WBACK, else FILL_REQ.
//   WBACK: mem_req_valid=1, write=1, addr={victim tag,IDX,0}, wdata=victim line; on ready -> FILL_REQ.
//   FILL_REQ: mem_req_valid=1, write=0, addr={TAG,IDX,0}; on ready -> FILL_WAIT.
//   FILL_WAIT: on mem_rvalid install line (valid=1, dirty=0, tag=TAG) -> LOOKUP (replay; now hits).
//  is_hit reports the first lookup only: a replayed hit after a miss completes with is_hit=0.
//  mem_req_* outputs are stable while valid&&!ready; mem_rvalid outside FILL_WAIT is ignored.
//  Clean-miss latency: accept + 1 (LOOKUP) + handshake + memory latency + 1 (install) + 1 (replay).
//  A store miss allocates: fill, then the replay merges din and sets dirty.
//  Counters wrap silently from 2^32-1 to 0.
// TESTING
//  1 Reset, load 0x100 (miss) with mem returning 128'h4_3_2_1 word pattern -> FILL req addr 0x100,
//    dout=word(0x100), is_hit=0, miss_count=1.
//  2 Load 0x104 after test 1 -> completes 1 cycle after accept, is_hit=1, hit_count=1,
//    no memory request issued.
//  3 2-way, NUM_SETS=16: store 0x000, 0x100, load 0x000, then store 0x200 (same set)
//    -> victim is 0x100 line; WBACK addr 0x100 precedes fill of 0x200.
//  4 Hold mem_req_ready=0 for 5 cycles during WBACK -> mem_req_* stable and is_ready=0 throughout;
//    completion follows ready.
//  5 Assert reset while in FILL_WAIT -> mem_req_valid=0 and is_ready=1 immediately;
//    next load 0x100 misses again.
//  6 NUM_WAYS=4, 5 distinct tags to one set, re-touching tag0 before the 5th
//    -> tag1 is evicted, a load of tag0 still hits.

Source files
------------

// File: rtl/set_assoc_cache.sv
// N-way set-associative, write-back, write-allocate data cache with true-LRU replacement
// and hit/miss statistics. Line fills and write-backs go through an external req/ready port.
module set_assoc_cache #(
  parameter int LINE_SIZE = 16,
  parameter int NUM_SETS  = 16,
  parameter int NUM_WAYS  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   is_input_valid,
  input  logic [31:0]            addr,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic [31:0]            din,
  output logic                   is_ready,
  output logic                   is_output_valid,
  output logic [31:0]            dout,
  output logic                   is_hit,
  output logic [31:0]            hit_count,
  output logic [31:0]            miss_count,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic                   mem_req_write,
  output logic [31:0]            mem_req_addr,
  output logic [8*LINE_SIZE-1:0] mem_wdata,
  input  logic                   mem_rvalid,
  input  logic [8*LINE_SIZE-1:0] mem_rdata,
  output logic [2:0]             dbg_state
);
  localparam int WPL      = LINE_SIZE / 4;
  localparam int OFF_BITS = $clog2(WPL);
  localparam int IDX_BITS = $clog2(NUM_SETS);
  localparam int OFF_W    = (OFF_BITS > 0) ? OFF_BITS : 1;
  localparam int IDX_W    = (IDX_BITS > 0) ? IDX_BITS : 1;
  localparam int AGE_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int TAG_W    = 30 - OFF_BITS - IDX_BITS;
  localparam int LINE_W   = 8 * LINE_SIZE;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOOKUP    = 3'd1;
  localparam logic [2:0] S_WBACK     = 3'd2;
  localparam logic [2:0] S_FILL_REQ  = 3'd3;
  localparam logic [2:0] S_FILL_WAIT = 3'd4;

  logic [2:0]        state;
  logic [31:0]       req_addr;
  logic [31:0]       req_din;
  logic              req_write;
  logic              replay;
  logic [AGE_W-1:0]  victim;

  logic              line_valid [NUM_SETS][NUM_WAYS];
  logic              line_dirty [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0]  line_tag   [NUM_SETS][NUM_WAYS];
  logic [AGE_W-1:0]  line_age   [NUM_SETS][NUM_WAYS];
  logic [LINE_W-1:0] line_data  [NUM_SETS][NUM_WAYS];

  logic [OFF_W-1:0]  req_off;
  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;

  assign req_off = OFF_W'((req_addr >> 2) & 32'(WPL - 1));
  assign req_idx = IDX_W'((req_addr >> (2 + OFF_BITS)) & 32'(NUM_SETS - 1));
  assign req_tag = req_addr[31 -: TAG_W];

  logic             hit;
  logic [AGE_W-1:0] hit_way;
  logic             inv_found;
  logic [AGE_W-1:0] inv_way;
  logic [AGE_W-1:0] lru_way;
  logic [AGE_W-1:0] old_age;
  logic [31:0]      hit_word;

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    lru_way   = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (line_valid[req_idx][w] && (line_tag[req_idx][w] == req_tag) && !hit) begin
        hit     = 1'b1;
        hit_way = AGE_W'(w);
      end
      if (!line_valid[req_idx][w] && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = AGE_W'(w);
      end
      if (line_age[req_idx][w] == AGE_W'(NUM_WAYS - 1)) lru_way = AGE_W'(w);
    end
    old_age  = line_age[req_idx][hit_way];
    hit_word = line_data[req_idx][hit_way][32*req_off +: 32];
  end

  // Memory port: a request is held with stable addr/write/wdata while mem_req_valid is high,
  // and is consumed on the posedge where mem_req_valid && mem_req_ready.
  assign is_ready      = (state == S_IDLE);
  assign mem_req_valid = (state == S_WBACK) || (state == S_FILL_REQ);
  assign mem_req_write = (state == S_WBACK);
  assign dbg_state     = state;

  always_comb begin
    mem_req_addr = '0;
    mem_wdata    = '0;
    if (state == S_WBACK) begin
      mem_req_addr = {line_tag[req_idx][victim], {(32-TAG_W){1'b0}}}
                   | (32'(req_idx) << (2 + OFF_BITS));
      mem_wdata    = line_data[req_idx][victim];
    end else if (state == S_FILL_REQ) begin
      mem_req_addr = {req_tag, {(32-TAG_W){1'b0}}} | (32'(req_idx) << (2 + OFF_BITS));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      req_addr        <= '0;
      req_din         <= '0;
      req_write       <= 1'b0;
      replay          <= 1'b0;
      victim          <= '0;
      is_output_valid <= 1'b0;
      dout            <= '0;
      is_hit          <= 1'b0;
      hit_count       <= '0;
      miss_count      <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          line_valid[s][w] <= 1'b0;
          line_dirty[s][w] <= 1'b0;
          line_tag[s][w]   <= '0;
          line_age[s][w]   <= AGE_W'(w);
        end
      end
    end else begin
      is_output_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (is_input_valid && (mem_read || mem_write)) begin
            req_addr  <= addr;
            req_din   <= din;
            req_write <= mem_write;
            replay    <= 1'b0;
            state     <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            is_output_valid <= 1'b1;
            is_hit          <= !replay;
            if (!req_write) dout <= hit_word;
            else line_dirty[req_idx][hit_way] <= 1'b1;
            if (!replay) hit_count <= hit_count + 32'd1;
            // Hit way becomes MRU; only ways younger than it age by one.
            for (int w = 0; w < NUM_WAYS; w++) begin
              if (AGE_W'(w) == hit_way) line_age[req_idx][w] <= '0;
              else if (line_age[req_idx][w] < old_age)
                line_age[req_idx][w] <= line_age[req_idx][w] + AGE_W'(1);
            end
            state <= S_IDLE;
          end else begin
            miss_count <= miss_count + 32'd1;
            victim     <= inv_found ? inv_way : lru_way;
            state      <= (!inv_found && line_dirty[req_idx][lru_way]) ? S_WBACK : S_FILL_REQ;
          end
        end
        S_WBACK:    if (mem_req_ready) state <= S_FILL_REQ;
        S_FILL_REQ: if (mem_req_ready) state <= S_FILL_WAIT;
        S_FILL_WAIT: begin
          if (mem_rvalid) begin
            line_valid[req_idx][victim] <= 1'b1;
            line_dirty[req_idx][victim] <= 1'b0;
            line_tag[req_idx][victim]   <= req_tag;
            replay                      <= 1'b1;
            state                       <= S_LOOKUP;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Line payload carries no reset; validity bits alone decide whether it is meaningful.
  always_ff @(posedge clk) begin
    if (state == S_FILL_WAIT && mem_rvalid)
      line_data[req_idx][victim] <= mem_rdata;
    else if (state == S_LOOKUP && hit && req_write)
      line_data[req_idx][hit_way][32*req_off +: 32] <= req_din;
  end
endmodule

// File: tb/tb_set_assoc_cache.sv
// Directed bench for set_assoc_cache: a 2-way instance and a 4-way instance share one
// CPU driver and one line-memory model; sel picks which instance is exercised.
module tb_set_assoc_cache;
  localparam int LW = 128;
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_FILL_REQ  = 3'd3;
  localparam logic [2:0] ST_FILL_WAIT = 3'd4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          sel;
  logic          in_valid, mem_read, mem_write;
  logic [31:0]   addr, din;
  logic          mem_req_ready, mem_rvalid;
  logic [LW-1:0] mem_rdata;

  logic a_is_ready, a_ov, a_is_hit, a_mreq_valid, a_mreq_write;
  logic b_is_ready, b_ov, b_is_hit, b_mreq_valid, b_mreq_write;
  logic [31:0] a_dout, a_hits, a_misses, a_mreq_addr;
  logic [31:0] b_dout, b_hits, b_misses, b_mreq_addr;
  logic [LW-1:0] a_wdata, b_wdata;
  logic [2:0] a_state, b_state;

  logic          is_ready, is_output_valid, is_hit, mreq_valid, mreq_write;
  logic [31:0]   dout, hit_count, miss_count, mreq_addr;
  logic [LW-1:0] mwdata;
  logic [2:0]    dbg_state;

  assign is_ready        = sel ? b_is_ready   : a_is_ready;
  assign is_output_valid = sel ? b_ov         : a_ov;
  assign is_hit          = sel ? b_is_hit     : a_is_hit;
  assign mreq_valid      = sel ? b_mreq_valid : a_mreq_valid;
  assign mreq_write      = sel ? b_mreq_write : a_mreq_write;
  assign dout            = sel ? b_dout       : a_dout;
  assign hit_count       = sel ? b_hits       : a_hits;
  assign miss_count      = sel ? b_misses     : a_misses;
  assign mreq_addr       = sel ? b_mreq_addr  : a_mreq_addr;
  assign mwdata          = sel ? b_wdata      : a_wdata;
  assign dbg_state       = sel ? b_state      : a_state;

  set_assoc_cache #(.LINE_SIZE(16), .NUM_SETS(16), .NUM_WAYS(2)) dut_a (
    .clk(clk), .reset(reset), .is_input_valid(in_valid & ~sel), .addr(addr),
    .mem_read(mem_read), .mem_write(mem_write), .din(din), .is_ready(a_is_ready),
    .is_output_valid(a_ov), .dout(a_dout), .is_hit(a_is_hit), .hit_count(a_hits),
    .miss_count(a_misses), .mem_req_valid(a_mreq_valid), .mem_req_ready(mem_req_ready),
    .mem_req_write(a_mreq_write), .mem_req_addr(a_mreq_addr), .mem_wdata(a_wdata),
    .mem_rvalid(mem_rvalid & ~sel), .mem_rdata(mem_rdata), .dbg_state(a_state));

  set_assoc_cache #(.LINE_SIZE(16), .NUM_SETS(16), .NUM_WAYS(4)) dut_b (
    .clk(clk), .reset(reset), .is_input_valid(in_valid & sel), .addr(addr),
    .mem_read(mem_read), .mem_write(mem_write), .din(din), .is_ready(b_is_ready),
    .is_output_valid(b_ov), .dout(b_dout), .is_hit(b_is_hit), .hit_count(b_hits),
    .miss_count(b_misses), .mem_req_valid(b_mreq_valid), .mem_req_ready(mem_req_ready),
    .mem_req_write(b_mreq_write), .mem_req_addr(b_mreq_addr), .mem_wdata(b_wdata),
    .mem_rvalid(mem_rvalid & sel), .mem_rdata(mem_rdata), .dbg_state(b_state));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard of expected memory requests, {write, line address}, in issue order.
  logic [32:0]   exp_q[$];
  int            mem_lat = 2;
  int            pend_cnt = 0;
  logic [31:0]   pend_addr;
  int            stall_cnt = 0;
  int            stall_seen = 0;
  int            stall_bad = 0;
  bit            stall_active = 0;
  logic [32:0]   snap_req;
  logic [LW-1:0] snap_wdata;
  logic [LW-1:0] last_wdata = '0;

  function automatic logic [LW-1:0] fill_line(input logic [31:0] a);
    logic [LW-1:0] l;
    for (int i = 0; i < 4; i++) l[32*i +: 32] = {a[15:0], 16'(i + 1)};
    return l;
  endfunction

  // Line memory: decides ready and spots handshakes at the negedge before the accepting posedge.
  initial begin
    mem_req_ready = 1'b1;
    mem_rvalid    = 1'b0;
    mem_rdata     = '0;
    forever begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      if (reset) begin
        pend_cnt = 0; stall_cnt = 0; stall_active = 0; mem_req_ready = 1'b1;
      end else begin
        if (pend_cnt > 0) begin
          pend_cnt--;
          if (pend_cnt == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = fill_line(pend_addr);
          end
        end
        if (mreq_valid && stall_cnt > 0) begin
          mem_req_ready = 1'b0;
          stall_cnt--;
          stall_seen++;
          if (!stall_active) begin
            stall_active = 1;
            snap_req     = {mreq_write, mreq_addr};
            snap_wdata   = mwdata;
          end else if ({mreq_write, mreq_addr} !== snap_req || mwdata !== snap_wdata) stall_bad++;
          if (is_ready !== 1'b0) stall_bad++;
        end else begin
          mem_req_ready = 1'b1;
          if (mreq_valid) begin
            if (stall_active && ({mreq_write, mreq_addr} !== snap_req || mwdata !== snap_wdata))
              stall_bad++;
            stall_active = 0;
            if (exp_q.size() == 0) chk("unexpected_req", {mreq_write, mreq_addr}, 33'h1_ffff_ffff);
            else chk("mem_req", {mreq_write, mreq_addr}, exp_q.pop_front());
            if (mreq_write) last_wdata = mwdata;
            else begin
              pend_cnt  = mem_lat;
              pend_addr = mreq_addr;
            end
          end
        end
      end
    end
  end

  logic [31:0] r_dout;
  logic        r_hit;
  int          r_cyc;

  task automatic issue(input bit wr, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    while (is_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    in_valid = 1'b1; mem_read = !wr; mem_write = wr; addr = a; din = d;
    @(negedge clk);
    in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] d);
    issue(wr, a, d);
    r_cyc = 0;
    while (is_output_valid !== 1'b1 && r_cyc < 200) begin @(negedge clk); r_cyc++; end
    chk("done", is_output_valid, 1'b1);
    r_dout = dout;
    r_hit  = is_hit;
  endtask

  task automatic wait_state(input logic [2:0] s);
    int n = 0;
    while (dbg_state !== s && n < 100) begin @(negedge clk); n++; end
    chk("reach_state", dbg_state, s);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; sel = 1'b0; in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    addr = '0; din = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    chk("rst_ready", is_ready, 1'b1);
    chk("rst_ov", is_output_valid, 1'b0);
    chk("rst_dout", dout, 32'h0);
    chk("rst_hit", is_hit, 1'b0);
    chk("rst_counts", {hit_count, miss_count}, 64'h0);
    chk("rst_mreq", {mreq_valid, mreq_write, mreq_addr}, 34'h0);
    chk("rst_wdata", mwdata, '0);

    // Test 1: clean load miss
    exp_q.push_back({1'b0, 32'h100});
    access(0, 32'h100, 32'h0);
    chk("t1_dout", r_dout, 32'h0100_0001);
    chk("t1_hit", r_hit, 1'b0);
    chk("t1_lat", r_cyc, 5);
    chk("t1_miss", miss_count, 32'd1);
    chk("t1_hits", hit_count, 32'd0);

    // Test 2: load hit, one cycle after accept, no memory traffic
    access(0, 32'h104, 32'h0);
    chk("t2_dout", r_dout, 32'h0100_0002);
    chk("t2_hit", r_hit, 1'b1);
    chk("t2_lat", r_cyc, 1);
    chk("t2_hits", hit_count, 32'd1);
    chk("t2_noreq", exp_q.size(), 0);

    // A request with no op set is ignored
    in_valid = 1'b1; addr = 32'h200;
    @(negedge clk);
    in_valid = 1'b0;
    chk("noop_state", dbg_state, ST_IDLE);
    chk("noop_ready", is_ready, 1'b1);

    // Test 3: dirty LRU victim written back before the fill
    exp_q.push_back({1'b0, 32'h000});
    access(1, 32'h000, 32'hAAAA_0000);
    chk("t3_st0_hit", r_hit, 1'b0);
    access(1, 32'h100, 32'hBBBB_1111);
    chk("t3_st1_hit", r_hit, 1'b1);
    access(0, 32'h000, 32'h0);
    chk("t3_ld0_dout", r_dout, 32'hAAAA_0000);
    chk("t3_ld0_hit", r_hit, 1'b1);
    exp_q.push_back({1'b1, 32'h100});
    exp_q.push_back({1'b0, 32'h200});
    access(1, 32'h200, 32'hCCCC_2222);
    chk("t3_st2_hit", r_hit, 1'b0);
    chk("t3_lat", r_cyc, 6);
    chk("t3_wdata", last_wdata, {32'h0100_0004, 32'h0100_0003, 32'h0100_0002, 32'hBBBB_1111});
    chk("t3_q", exp_q.size(), 0);

    // Test 4: write-back held off by five not-ready cycles
    stall_cnt = 5; stall_seen = 0; stall_bad = 0;
    exp_q.push_back({1'b1, 32'h000});
    exp_q.push_back({1'b0, 32'h300});
    access(0, 32'h300, 32'h0);
    chk("t4_dout", r_dout, 32'h0300_0001);
    chk("t4_lat", r_cyc, 11);
    chk("t4_stall_seen", stall_seen, 5);
    chk("t4_stable", stall_bad, 0);
    chk("t4_wdata", last_wdata, {32'h0000_0004, 32'h0000_0003, 32'h0000_0002, 32'hAAAA_0000});
    chk("t4_counts", {hit_count, miss_count}, {32'd3, 32'd4});

    // Test 5: reset in FILL_WAIT and in a stalled FILL_REQ
    mem_lat = 10;
    exp_q.push_back({1'b0, 32'h510});
    issue(0, 32'h510, 32'h0);
    wait_state(ST_FILL_WAIT);
    chk("t5_busy", is_ready, 1'b0);
    reset = 1'b1;
    #1;
    chk("t5_mreq", mreq_valid, 1'b0);
    chk("t5_ready", is_ready, 1'b1);
    chk("t5_ov", is_output_valid, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    mem_lat = 2;
    stall_cnt = 4;
    issue(0, 32'h520, 32'h0);
    wait_state(ST_FILL_REQ);
    chk("t5_req_up", mreq_valid, 1'b1);
    reset = 1'b1;
    #1;
    chk("t5_req_drop", mreq_valid, 1'b0);
    chk("t5_ready2", is_ready, 1'b1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.push_back({1'b0, 32'h100});
    access(0, 32'h100, 32'h0);
    chk("t5_hit", r_hit, 1'b0);
    chk("t5_dout", r_dout, 32'h0100_0001);
    chk("t5_counts", {hit_count, miss_count}, {32'd0, 32'd1});

    // Test 6: 4-way true LRU
    sel = 1'b1;
    do_reset();
    for (int t = 0; t < 4; t++) begin
      exp_q.push_back({1'b0, 32'(t) << 8});
      access(0, 32'(t) << 8, 32'h0);
      chk("t6_fill_hit", r_hit, 1'b0);
    end
    access(0, 32'h000, 32'h0);
    chk("t6_touch_hit", r_hit, 1'b1);
    chk("t6_touch_dout", r_dout, 32'h0000_0001);
    exp_q.push_back({1'b0, 32'h400});
    access(0, 32'h400, 32'h0);
    chk("t6_t4_hit", r_hit, 1'b0);
    chk("t6_t4_dout", r_dout, 32'h0400_0001);
    access(0, 32'h000, 32'h0);
    chk("t6_t0_hit", r_hit, 1'b1);
    exp_q.push_back({1'b0, 32'h100});
    access(0, 32'h100, 32'h0);
    chk("t6_t1_hit", r_hit, 1'b0);
    chk("t6_counts", {hit_count, miss_count}, {32'd2, 32'd6});
    chk("final_q", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
